// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Raises STALL while a divide occupies EX; DONE pulses for one cycle with RESULT valid.
module ex_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_op_rem;
    logic [WIDTH-1:0] r_result;

    // Operand decode used at the accept edge
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_special_result;

    assign w_signed   = ~i_op[0];
    assign w_a_neg    = w_signed & i_a[WIDTH-1];
    assign w_b_neg    = w_signed & i_b[WIDTH-1];
    assign w_a_mag    = w_a_neg ? (~i_a + WIDTH'(1)) : i_a;
    assign w_b_mag    = w_b_neg ? (~i_b + WIDTH'(1)) : i_b;
    assign w_div_zero = (i_b == '0);
    assign w_ovf      = w_signed & (i_a == MIN_INT) & (i_b == '1);
    assign w_special  = w_div_zero | w_ovf;

    always_comb begin
        w_special_result = '0;
        if (w_div_zero) begin
            w_special_result = i_op[1] ? i_a : '1;
        end else begin
            w_special_result = i_op[1] ? '0 : MIN_INT;
        end
    end

    // One restoring step: the shifted remainder is WIDTH+1 bits wide, but once the
    // trial subtraction succeeds the difference always fits back into WIDTH bits.
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_final;
    logic             w_last;

    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_divisor});
    assign w_diff     = w_shift[WIDTH-1:0] - r_divisor;
    assign w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};
    assign w_last     = (r_count == CW'(WIDTH-1));

    always_comb begin
        w_final = '0;
        if (r_op_rem) begin
            w_final = r_neg_r ? (~w_rem_next + WIDTH'(1)) : w_rem_next;
        end else begin
            w_final = r_neg_q ? (~w_quo_next + WIDTH'(1)) : w_quo_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_next = w_special ? S_FIN : S_CALC;
            S_CALC: if (w_last) w_state_next = S_FIN;
            S_FIN:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (i_flush) begin
            w_state_next = S_IDLE;
        end
    end

    // Flush leaves every datapath register untouched, so RESULT keeps its last value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count   <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_op_rem  <= 1'b0;
            r_result  <= '0;
        end else if (!i_flush) begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_special) begin
                            r_result <= w_special_result;
                        end else begin
                            r_quo     <= w_a_mag;
                            r_divisor <= w_b_mag;
                            r_rem     <= '0;
                            r_count   <= '0;
                            r_neg_q   <= (i_op == 2'b00) & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                            r_neg_r   <= (i_op == 2'b10) & i_a[WIDTH-1];
                            r_op_rem  <= i_op[1];
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_result <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_stall     = ((r_state == S_IDLE) && i_start) || (r_state == S_CALC);
    assign o_done      = (r_state == S_FIN);
    assign o_result    = r_result;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: hand-computed results, latency, STALL, FLUSH and RESET behaviour.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  ex_div_unit #(.WIDTH(32)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_op        (op),
    .i_a         (a),
    .i_b         (b),
    .i_flush     (flush),
    .o_busy      (busy),
    .o_stall     (stall),
    .o_done      (done),
    .o_result    (result),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Runs one op starting 1 time unit after an edge. n_edges counts edges from
  // the accept edge (inclusive) to the one after which DONE is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int n_edges,
                        output logic stall_pre, output int stall_cyc, output logic stall_done);
    op = o; a = x; b = y; start = 1'b1;
    n_edges = 0; stall_cyc = 0; stall_done = 1'b1;
    #1;
    stall_pre = stall;
    while (n_edges < 100) begin
      @(posedge clk); #1;
      n_edges++;
      if (done) break;
      if (stall) stall_cyc++;
    end
    res = result;
    stall_done = stall;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected %h", result, 32'h0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset = 1'b0;
    start = 1'b1; #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_follows_start_hi: got %b expected 1", stall); end
    start = 1'b0; #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_follows_start_lo: got %b expected 0", stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_table(input string tag, input int n,
                            input logic [1:0] vo[8], input logic [31:0] va[8],
                            input logic [31:0] vb[8], input logic [31:0] ve[8], input int exp_edges);
    logic [31:0] res;
    int          n_edges;
    logic        s_pre;
    int          s_cyc;
    logic        s_done;
    int          exp_stall;
    exp_stall = (exp_edges == 1) ? 0 : 32;
    for (int i = 0; i < n; i++) begin
      run_op(vo[i], va[i], vb[i], res, n_edges, s_pre, s_cyc, s_done);
      n_cmp++; if (res !== ve[i]) begin n_fail++; $display("FAIL %s[%0d]_result: got %h expected %h", tag, i, res, ve[i]); end
      n_cmp++; if (n_edges !== exp_edges) begin n_fail++; $display("FAIL %s[%0d]_latency: got %0d expected %0d", tag, i, n_edges, exp_edges); end
      n_cmp++; if (s_pre !== 1'b1) begin n_fail++; $display("FAIL %s[%0d]_stall_pre: got %b expected 1", tag, i, s_pre); end
      n_cmp++; if (s_cyc !== exp_stall) begin n_fail++; $display("FAIL %s[%0d]_stall_cycles: got %0d expected %0d", tag, i, s_cyc, exp_stall); end
      n_cmp++; if (s_done !== 1'b0) begin n_fail++; $display("FAIL %s[%0d]_stall_at_done: got %b expected 0", tag, i, s_done); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s[%0d]_idle_after: got %b expected 0", tag, i, busy); end
    end
  endtask

  task automatic test_unsigned();
    logic [1:0]  vo[8] = '{2'b01, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [31:0] va[8] = '{32'd100, 32'd100, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0};
    logic [31:0] vb[8] = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 0};
    logic [31:0] ve[8] = '{32'd14, 32'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0};
    test_table("unsigned", 4, vo, va, vb, ve, 33);
  endtask

  task automatic test_signed();
    logic [1:0]  vo[8] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [31:0] va[8] = '{-32'sd100, -32'sd100, 32'd100, 32'h80000000, 0, 0, 0, 0};
    logic [31:0] vb[8] = '{32'd7, 32'd7, -32'sd7, 32'd2, 0, 0, 0, 0};
    logic [31:0] ve[8] = '{32'hFFFFFFF2, 32'hFFFFFFFE, 32'd2, 32'hC0000000, 0, 0, 0, 0};
    test_table("signed", 4, vo, va, vb, ve, 33);
  endtask

  task automatic test_div_zero();
    logic [1:0]  vo[8] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [31:0] va[8] = '{32'd5, 32'd5, -32'sd5, 32'd7, 0, 0, 0, 0};
    logic [31:0] vb[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] ve[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'd7, 0, 0, 0, 0};
    test_table("divzero", 4, vo, va, vb, ve, 1);
  endtask

  task automatic test_overflow();
    logic [1:0]  vo[8] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [31:0] va[8] = '{32'h80000000, 32'h80000000, 0, 0, 0, 0, 0, 0};
    logic [31:0] vb[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0};
    logic [31:0] ve[8] = '{32'h80000000, 32'h0, 0, 0, 0, 0, 0, 0};
    test_table("overflow", 2, vo, va, vb, ve, 1);
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int          n_edges;
    logic        s_pre;
    int          s_cyc;
    logic        s_done;
    int          seen;
    run_op(2'b01, 32'd100, 32'd7, res, n_edges, s_pre, s_cyc, s_done);
    n_cmp++; if (res !== 32'd14) begin n_fail++; $display("FAIL flush_setup_result: got %h expected %h", res, 32'd14); end
    op = 2'b00; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_calc_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_calc_done: got %b expected 0", done); end
    n_cmp++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_calc_result: got %h expected %h", result, 32'd14); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses expected 0", seen); end
    op = 2'b01; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL flush_start_idle: got %0d expected 0", dbg_state); end
    start = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_start_result: got %h expected %h", result, 32'd14); end
  endtask

  task automatic test_reset_mid();
    op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_busy_before: got %b expected 1", busy); end
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_done: got %b expected 0", done); end
    n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_mid_result: got %h expected %h", result, 32'h0); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int          cyc = 0;
    int          t1 = 0;
    int          t2 = 0;
    logic [31:0] r1 = '0;
    logic [31:0] r2 = '0;
    op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
    while (cyc < 150) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        if (t1 == 0) begin
          t1 = cyc; r1 = result; a = 32'd9; b = 32'd3;
        end else begin
          t2 = cyc; r2 = result;
          break;
        end
      end
    end
    start = 1'b0;
    n_cmp++; if (t1 !== 33) begin n_fail++; $display("FAIL b2b_first_time: got %0d expected 33", t1); end
    n_cmp++; if (t2 - t1 !== 34) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 34", t2 - t1); end
    n_cmp++; if (r1 !== 32'd14) begin n_fail++; $display("FAIL b2b_result1: got %h expected %h", r1, 32'd14); end
    n_cmp++; if (r2 !== 32'd3) begin n_fail++; $display("FAIL b2b_result2: got %h expected %h", r2, 32'd3); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Iterative divider for the RV32M DIV/DIVU/REM/REMU instructions. It lives in the EX stage and is fed by the ID/EX pipeline register outputs (operands and decoded ALU op). It produces one result per instruction using a radix-2 restoring algorithm. While it works it raises STALL so the hazard unit freezes PC, IF/ID and ID/EX.

## Interface
- WIDTH, 32: operand and result width. The iteration count equals WIDTH.

- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- START  in  1  a divide op is present in EX; held high for the whole time the instruction sits in EX
- OP  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- A  in  WIDTH  dividend (rs1)
- B  in  WIDTH  divisor (rs2)
- FLUSH  in  1  abort the in-flight divide (branch/jump flush of EX)
- BUSY  out  1  state ≠ IDLE
- STALL  out  1  combinational: (state==IDLE && START) || state==CALC
- DONE  out  1  one-cycle pulse; RESULT is valid
- RESULT  out  WIDTH  registered result, held until the next load

## Operation
- States:
  - IDLE: waits for START.
  - CALC: runs iterations.
  - FIN: DONE=1 for one cycle, then returns to IDLE.
- Priority at every edge: RESET > FLUSH > normal operation.
- IDLE, START=1, normal operands:
  - Latch |A| and |B| (signed ops) or raw A and B (unsigned ops).
  - Latch the quotient-negate flag: DIV with sign(A)≠sign(B).
  - Latch the remainder-negate flag: REM with A negative.
  - Clear the 33-bit partial remainder and set count=0.
  - Go to CALC.
- CALC step, MSB first:
  - Shift remainder left 1 and take in the next dividend bit.
  - Trial-subtract the divisor. If the result is ≥0, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - count increments by 1. On the step where count==WIDTH-1, load RESULT with the sign-corrected quotient (OP[1]=0) or remainder (OP[1]=1), then go to FIN.
- Magnitude arithmetic is unsigned WIDTH-bit. |0x80000000| = 0x80000000, which is legal. Negation is two's complement truncated to WIDTH.
- Special cases are resolved in IDLE with no CALC phase. RESULT is loaded at the accept edge and the state goes to FIN.
  - B==0: quotient = all ones (DIV and DIVU); remainder = A (REM and REMU).
  - DIV/REM with A==0x80000000 and B==0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- FIN: DONE=1 and START is ignored. Next edge goes to IDLE. The instruction leaves EX at that edge because STALL is already low.
- FLUSH in any state: next state is IDLE. DONE is not asserted and RESULT is unchanged. A START arriving on the same edge is dropped.
- Reset values:
  - state IDLE, RESULT 0, DONE 0, BUSY 0, count 0.
  - STALL follows START (combinational from IDLE).

## Timing
- Accept edge E0: START sampled high in IDLE.
- Normal op:
  - CALC covers edges E1..E32.
  - RESULT is loaded at E32, and DONE is high between E32 and E33.
  - Latency is 32 cycles from E0 to DONE.
  - STALL is high from the cycle START rises through the cycle before E32.
- Special case: RESULT is loaded at E0, DONE is high between E0 and E1, and STALL is high for one cycle only.
- Back-to-back divides:
  - The next instruction enters EX at E33, with state IDLE.
  - Its START is sampled at E34, so there is no gap bubble beyond that single accept cycle.
- RESULT holds its value through IDLE and is never cleared except by RESET.
- RESET mid-CALC: at the next edge all registers take their reset values and any partial result is discarded.

## Test plan
- DIVU 100/7 at E0 → DONE high exactly after E32 with RESULT=14. REMU 100/7 → 2. STALL high for 32 cycles then low.
- Signed ops:
  - DIV -100/7 → 0xFFFFFFF2.
  - REM -100/7 → 0xFFFFFFFE.
  - REM 100/-7 → 2.
  - DIV 0x80000000/2 → 0xC0000000.
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF.
  - DIV 5/0 → 0xFFFFFFFF.
  - REM -5/0 → 0xFFFFFFFB.
  - DONE asserts one cycle after the accept edge.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, both with 1-cycle latency.
- FLUSH asserted at the 10th CALC cycle → IDLE at the next edge, no DONE pulse, RESULT still holds the previous value (e.g. 14). FLUSH together with START in IDLE → stays IDLE.
- RESET asserted mid-CALC → BUSY=0, DONE=0, RESULT=0 at the next edge. Two consecutive DIVU ops with START held (100/7, then 9/3) → DONE pulses 34 cycles apart with RESULT=14, then 3.
